// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage core: decides per cycle which pipeline
// registers advance, hold or squash, and keeps saturating stall/flush counters.
module hazard_stall_ctrl #(
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             err_clear,
    input  logic             cnt_clear,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             mem_error,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR  = 2'b10
    } state_t;

    localparam int               WC_W      = $clog2(TIMEOUT) + 1;
    localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WC_W-1:0]  wait_cnt_r;
    logic [WC_W-1:0]  wait_nxt_s;
    logic             mem_error_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    logic load_use_s;
    logic mem_stall_s;
    logic advance_s;
    logic hold_front_s;

    assign load_use_s  = ex_mem_read && (ex_rd != {REG_W{1'b0}}) &&
                         ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign mem_stall_s = mem_req && !mem_ready;
    // A taken branch squashes the ID instruction, so load-use only holds PC/IF-ID without it.
    assign hold_front_s = load_use_s && !ex_branch_taken;

    // Next-state, wait counter and whether the pipeline advances this cycle.
    always_comb begin
        state_nxt_s = state_r;
        wait_nxt_s  = wait_cnt_r;
        advance_s   = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (mem_stall_s) begin
                    state_nxt_s = ST_WAIT;
                    wait_nxt_s  = WC_W'(1);
                end else begin
                    advance_s = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    advance_s   = 1'b1;
                    state_nxt_s = ST_RUN;
                    wait_nxt_s  = {WC_W{1'b0}};
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    wait_nxt_s = wait_cnt_r + WC_W'(1);
                end
            end
            ST_ERR: begin
                if (err_clear) begin
                    state_nxt_s = ST_RUN;
                    wait_nxt_s  = {WC_W{1'b0}};
                end else begin
                    state_nxt_s = ST_ERR;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                wait_nxt_s  = {WC_W{1'b0}};
            end
        endcase
    end

    assign pc_write     = advance_s && !hold_front_s;
    assign if_id_write  = advance_s && !hold_front_s;
    assign if_id_flush  = advance_s && ex_branch_taken;
    assign id_ex_write  = advance_s;
    assign id_ex_bubble = advance_s && (ex_branch_taken || load_use_s);
    assign ex_mem_write = advance_s;
    assign mem_wb_write = advance_s;

    // State, wait counter and error flag registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r     <= ST_RUN;
            wait_cnt_r  <= {WC_W{1'b0}};
            mem_error_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            wait_cnt_r  <= wait_nxt_s;
            mem_error_r <= (state_nxt_s == ST_ERR);
        end
    end

    // Saturating performance counters; cnt_clear beats increment.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clear) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (!pc_write && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (if_id_flush && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign state     = state_r;
    assign mem_error = mem_error_r;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed literal checks plus randomized stimulus
// compared each cycle against a rule-level reference model.
module tb_hazard_stall_ctrl;
    localparam int REG_W   = 5;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             arst_n;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd;
    logic             id_uses_rt, ex_mem_read, ex_branch_taken;
    logic             mem_req, mem_ready, err_clear, cnt_clear;
    logic             pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
    logic             ex_mem_write, mem_wb_write, mem_error;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_stall_ctrl #(.REG_W(REG_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .arst_n(arst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .err_clear(err_clear), .cnt_clear(cnt_clear),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write),
        .mem_wb_write(mem_wb_write), .mem_error(mem_error), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0=run, 1=waiting on memory, 2=error
    int   m_mode, m_waited, m_stall, m_flush;
    logic e_pc, e_ifid, e_flush, e_idex, e_bubble, e_exmem, e_memwb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_eval();
        bit lu, frozen;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
        frozen = (m_mode == 2) || (m_mode == 0 && mem_req && !mem_ready) ||
                 (m_mode == 1 && !mem_ready);
        {e_pc, e_ifid, e_flush, e_idex, e_bubble, e_exmem, e_memwb} = 7'b0;
        if (!frozen) begin
            {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b11111;
            if (ex_branch_taken) begin
                e_flush = 1'b1; e_bubble = 1'b1;
            end else if (lu) begin
                e_pc = 1'b0; e_ifid = 1'b0; e_bubble = 1'b1;
            end
        end
    endtask

    task automatic model_update();
        if (cnt_clear) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if (!e_pc && m_stall < CMAX) m_stall++;
            if (e_flush && m_flush < CMAX) m_flush++;
        end
        if (m_mode == 0) begin
            if (mem_req && !mem_ready) begin m_mode = 1; m_waited = 1; end
        end else if (m_mode == 1) begin
            if (mem_ready) m_mode = 0;
            else begin
                m_waited++;
                if (m_waited == TIMEOUT) m_mode = 2;
            end
        end else if (err_clear) begin
            m_mode = 0;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
        chk("pc_write", pc_write, e_pc);
        chk("if_id_write", if_id_write, e_ifid);
        chk("if_id_flush", if_id_flush, e_flush);
        chk("id_ex_write", id_ex_write, e_idex);
        chk("id_ex_bubble", id_ex_bubble, e_bubble);
        chk("ex_mem_write", ex_mem_write, e_exmem);
        chk("mem_wb_write", mem_wb_write, e_memwb);
        chk("state", state, m_mode);
        chk("mem_error", mem_error, (m_mode == 2));
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        err_clear = 1'b0; cnt_clear = 1'b0;
    endtask

    // Called just after a rising edge; reset takes effect without waiting for the clock.
    task automatic do_reset();
        arst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_state", state, 0);
        chk("rst_mem_error", mem_error, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        #2;
        arst_n = 1'b1;
    endtask

    initial begin
        idle();
        arst_n = 1'b0;
        model_reset();
        #12 arst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state with idle inputs
        settle(); chk("lit_reset_pc", pc_write, 1); chk("lit_reset_flush", if_id_flush, 0);
        chk("lit_reset_cnt", stall_cnt, 0); tick();

        // Load-use on rs
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        settle(); chk("lit_lu_pc", pc_write, 0); chk("lit_lu_ifid", if_id_write, 0);
        chk("lit_lu_bubble", id_ex_bubble, 1); chk("lit_lu_exmem", ex_mem_write, 1);
        tick(); chk("lit_lu_stall_cnt", stall_cnt, 1);

        // Register zero never stalls
        ex_rd = 5'd0; id_rs = 5'd0;
        settle(); chk("lit_r0_pc", pc_write, 1); tick();

        // rt filter
        ex_rd = 5'd7; id_rt = 5'd7; id_rs = 5'd1; id_uses_rt = 1'b0;
        settle(); chk("lit_rt_off_pc", pc_write, 1); tick();
        id_uses_rt = 1'b1;
        settle(); chk("lit_rt_on_pc", pc_write, 0); tick();

        // Branch over load-use
        ex_branch_taken = 1'b1;
        settle(); chk("lit_br_flush", if_id_flush, 1); chk("lit_br_bubble", id_ex_bubble, 1);
        chk("lit_br_pc", pc_write, 1);
        tick(); chk("lit_br_flush_cnt", flush_cnt, 1); chk("lit_br_stall_cnt", stall_cnt, 2);

        // Memory wait of 3 cycles after clearing counters
        idle(); cnt_clear = 1'b1; settle(); tick(); chk("lit_clr", stall_cnt, 0);
        idle(); mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle(); chk("lit_mw_frozen", pc_write | ex_mem_write | mem_wb_write, 0);
            tick(); chk("lit_mw_state", state, 1);
        end
        chk("lit_mw_stall_cnt", stall_cnt, 3);
        mem_ready = 1'b1;
        settle(); chk("lit_rel_writes", {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write}, 5'b11111);
        tick(); chk("lit_rel_state", state, 0);

        // Timeout into ERROR, then clear while mem_req still stalls
        mem_ready = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin settle(); tick(); end
        chk("lit_to_state", state, 2); chk("lit_to_err", mem_error, 1);
        settle(); chk("lit_err_frozen", pc_write, 0); tick();
        err_clear = 1'b1;
        settle(); chk("lit_clr_frozen", pc_write, 0); tick();
        chk("lit_clr_state", state, 0); chk("lit_clr_err", mem_error, 0);
        err_clear = 1'b0;
        settle(); chk("lit_rewait_pc", pc_write, 0); tick(); chk("lit_rewait_state", state, 1);

        // Reset asserted mid-wait
        do_reset();
        idle();
        settle(); chk("lit_post_rst_pc", pc_write, 1); tick();

        // Saturation, then clear beating a stall
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs = 5'd3;
        for (int i = 0; i < CMAX + 2; i++) begin settle(); tick(); end
        chk("lit_sat", stall_cnt, CMAX);
        cnt_clear = 1'b1; settle(); tick(); chk("lit_sat_clr", stall_cnt, 0);

        // Randomized stimulus
        for (int c = 0; c < 3000; c++) begin
            id_rs           = REG_W'($urandom_range(0, 3));
            id_rt           = REG_W'($urandom_range(0, 3));
            ex_rd           = REG_W'($urandom_range(0, 3));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 3) == 0);
            mem_req         = ($urandom_range(0, 2) == 0) || (m_mode != 0 && $urandom_range(0, 3) != 0);
            mem_ready       = ($urandom_range(0, 2) == 0);
            err_clear       = ($urandom_range(0, 3) == 0);
            cnt_clear       = ($urandom_range(0, 63) == 0);
            if (c % 700 == 699) do_reset();
            settle();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
